simple_axi_to_axi_write_burst: RTL and testbench

Bridges the codebase's simple write interface to a full AXI4 write master port, generalising the single-width, 32-bit, 8-bit-length bridge. It supports any power-of-two data width, byte lengths up to LEN_W bits, a configurable maximum burst size and automatic 4 KB boundary splitting. It masks the strobe on a partial final beat and reports the merged write response back to the simple side. It sits between Versat units that produce write streams and the system AXI interconnect, with one burst outstanding at a time.

---
 rtl/versat_axi_pkg.sv | 37 +++
 rtl/simple_axi_burst_calc.sv | 41 ++++
 rtl/simple_axi_to_axi_write_burst.sv | 231 +++++++++++++++++++++++
 tb/tb_simple_axi_to_axi_write_burst.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/versat_axi_pkg.sv
// Shared AXI definitions for the Versat write bridges: burst and response
// encodings, the 4 KB boundary size, FSM state type and size encoding.
package versat_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // A burst must never cross this many bytes of address space.
    localparam int AXI_4KB_BYTES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_AW,
        ST_W,
        ST_B,
        ST_GAP,
        ST_DONE
    } wr_state_e;

    // AXI awsize encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size_enc(input int unsigned bytes);
        logic [2:0] enc;
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (32'd1 << i)) begin
                enc = 3'(i);
            end
        end
        return enc;
    endfunction

endpackage

// File: rtl/simple_axi_burst_calc.sv
// Combinational burst sizing: the largest burst that fits the remaining
// beats, the maximum burst length and the distance to the next 4 KB page.
module simple_axi_burst_calc
    import versat_axi_pkg::*;
#(
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int LEN_W      = 20,
    parameter int MAX_BURST  = 256
) (
    input  logic [11:0]          addr_ofs_i,
    input  logic [LEN_W:0]       beats_left_i,
    output logic [LEN_W:0]       burst_o,
    output logic [AXI_LEN_W-1:0] awlen_o
);

    localparam int BYTES = AXI_DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    // Compare width wide enough for both the beat count and the page distance.
    localparam int CW    = (LEN_W + 1 > 14) ? LEN_W + 1 : 14;

    logic [12:0]   dist_bytes;
    logic [CW-1:0] dist_beats;
    logic [CW-1:0] cand;

    // Minimum of remaining beats, MAX_BURST and beats left in the 4 KB page.
    always_comb begin
        dist_bytes = 13'(AXI_4KB_BYTES) - {1'b0, addr_ofs_i};
        dist_beats = CW'(dist_bytes >> SIZE);
        cand       = CW'(beats_left_i);
        if (CW'(MAX_BURST) < cand) begin
            cand = CW'(MAX_BURST);
        end
        if (dist_beats < cand) begin
            cand = dist_beats;
        end
        burst_o = (LEN_W + 1)'(cand);
        awlen_o = AXI_LEN_W'(cand - CW'(1));
    end

endmodule

// File: rtl/simple_axi_to_axi_write_burst.sv
// Simple write interface to AXI4 write master bridge. Splits a byte-length
// request into INCR bursts (max length and 4 KB limited), masks the strobe
// of a partial final beat and returns the worst write response seen.
module simple_axi_to_axi_write_burst
    import versat_axi_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int LEN_W      = 20,
    parameter int MAX_BURST  = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    m_wvalid_i,
    output logic                    m_wready_o,
    input  logic [AXI_ADDR_W-1:0]   m_waddr_i,
    input  logic [LEN_W-1:0]        m_wlen_i,
    input  logic [AXI_DATA_W-1:0]   m_wdata_i,
    output logic                    m_wlast_o,
    output logic                    m_wdone_o,
    output logic [1:0]              m_wresp_o,
    output logic [AXI_ID_W-1:0]     axi_awid_o,
    output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]    axi_awlen_o,
    output logic [2:0]              axi_awsize_o,
    output logic [1:0]              axi_awburst_o,
    output logic                    axi_awlock_o,
    output logic [3:0]              axi_awcache_o,
    output logic [2:0]              axi_awprot_o,
    output logic [3:0]              axi_awqos_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [AXI_DATA_W-1:0]   axi_wdata_o,
    output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
    output logic                    axi_wlast_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic [AXI_ID_W-1:0]     axi_bid_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o
);

    localparam int         BYTES   = AXI_DATA_W / 8;
    localparam int         SIZE    = $clog2(BYTES);
    localparam logic [2:0] AW_SIZE = axi_size_enc(BYTES);

    wr_state_e              state_q, state_d;
    logic [AXI_ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W:0]         beats_left_q, beats_left_d;
    logic [SIZE-1:0]        rem_q, rem_d;
    logic [LEN_W:0]         burst_q, burst_d;
    logic [AXI_ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [AXI_LEN_W-1:0]   awlen_q, awlen_d;
    logic                   awvalid_q, awvalid_d;
    logic [AXI_LEN_W-1:0]   cnt_q, cnt_d;
    logic                   bready_q, bready_d;
    logic [1:0]             resp_acc_q, resp_acc_d;

    logic [LEN_W:0]         req_beats;
    logic [LEN_W:0]         calc_burst;
    logic [AXI_LEN_W-1:0]   calc_awlen;
    logic                   final_beat;
    logic                   bid_unused;

    // Only one burst is ever outstanding, so the returned ID carries no information.
    assign bid_unused = ^axi_bid_i;

    // Beats needed for the request, rounding a partial last beat up.
    assign req_beats = ({1'b0, m_wlen_i} + (LEN_W + 1)'(BYTES - 1)) >> SIZE;

    simple_axi_burst_calc #(
        .AXI_DATA_W (AXI_DATA_W),
        .AXI_LEN_W  (AXI_LEN_W),
        .LEN_W      (LEN_W),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .addr_ofs_i   (addr_q[11:0]),
        .beats_left_i (beats_left_q),
        .burst_o      (calc_burst),
        .awlen_o      (calc_awlen)
    );

    // Registered AW channel and fixed attributes; data passes straight through.
    assign axi_awid_o    = '0;
    assign axi_awaddr_o  = awaddr_q;
    assign axi_awlen_o   = awlen_q;
    assign axi_awsize_o  = AW_SIZE;
    assign axi_awburst_o = AXI_BURST_INCR;
    assign axi_awlock_o  = 1'b0;
    assign axi_awcache_o = 4'd0;
    assign axi_awprot_o  = 3'd0;
    assign axi_awqos_o   = 4'd0;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wdata_o   = m_wdata_i;
    assign axi_bready_o  = bready_q;

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            rem_q        <= '0;
            burst_q      <= '0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            awvalid_q    <= 1'b0;
            cnt_q        <= '0;
            bready_q     <= 1'b0;
            resp_acc_q   <= AXI_RESP_OKAY;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            rem_q        <= rem_d;
            burst_q      <= burst_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            awvalid_q    <= awvalid_d;
            cnt_q        <= cnt_d;
            bready_q     <= bready_d;
            resp_acc_q   <= resp_acc_d;
        end
    end

    // Next-state logic and the combinational W-channel / completion outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        rem_d        = rem_q;
        burst_d      = burst_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        awvalid_d    = awvalid_q;
        cnt_d        = cnt_q;
        bready_d     = bready_q;
        resp_acc_d   = resp_acc_q;
        m_wready_o   = 1'b0;
        m_wlast_o    = 1'b0;
        m_wdone_o    = 1'b0;
        m_wresp_o    = AXI_RESP_OKAY;
        axi_wvalid_o = 1'b0;
        axi_wlast_o  = 1'b0;
        axi_wstrb_o  = '0;
        final_beat   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_wvalid_i) begin
                    addr_d       = m_waddr_i;
                    beats_left_d = req_beats;
                    rem_d        = m_wlen_i[SIZE-1:0];
                    resp_acc_d   = AXI_RESP_OKAY;
                    state_d      = (m_wlen_i == '0) ? ST_DONE : ST_CALC;
                end
            end

            ST_CALC: begin
                burst_d   = calc_burst;
                awlen_d   = calc_awlen;
                awaddr_d  = addr_q;
                awvalid_d = 1'b1;
                state_d   = ST_AW;
            end

            ST_AW: begin
                if (axi_awready_i) begin
                    awvalid_d    = 1'b0;
                    addr_d       = addr_q + (AXI_ADDR_W'(burst_q) << SIZE);
                    beats_left_d = beats_left_q - burst_q;
                    cnt_d        = '0;
                    state_d      = ST_W;
                end
            end

            ST_W: begin
                axi_wvalid_o = m_wvalid_i;
                m_wready_o   = axi_wready_i;
                axi_wlast_o  = (cnt_q == awlen_q);
                // beats_left already excludes this burst, so zero marks the last one.
                final_beat   = axi_wlast_o && (beats_left_q == '0);
                m_wlast_o    = m_wready_o && final_beat;
                if (final_beat && (rem_q != '0)) begin
                    for (int i = 0; i < BYTES; i++) begin
                        axi_wstrb_o[i] = (i < int'(rem_q));
                    end
                end else begin
                    axi_wstrb_o = '1;
                end
                if (m_wvalid_i && axi_wready_i) begin
                    cnt_d = cnt_q + AXI_LEN_W'(1);
                    if (axi_wlast_o) begin
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end
                end
            end

            ST_B: begin
                if (axi_bvalid_i) begin
                    // Response codes are ordered by severity, so max keeps the worst.
                    if (axi_bresp_i > resp_acc_q) begin
                        resp_acc_d = axi_bresp_i;
                    end
                    bready_d = 1'b0;
                    state_d  = (beats_left_q == '0) ? ST_DONE : ST_GAP;
                end
            end

            ST_GAP: begin
                // Idle cycle lets the interconnect re-arbitrate between bursts.
                state_d = ST_CALC;
            end

            ST_DONE: begin
                m_wdone_o = 1'b1;
                m_wresp_o = resp_acc_q;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simple_axi_to_axi_write_burst.sv
// Scoreboard bench for the simple-to-AXI write burst bridge (32- and 64-bit instances).
module tb_simple_axi_to_axi_write_burst;
    import versat_axi_pkg::*;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        m_wvalid;
    logic [31:0] m_waddr;
    logic [19:0] m_wlen;
    logic [63:0] m_wdata;
    logic        awready, wready, bvalid;
    logic [1:0]  bresp;
    logic        bid;

    logic a_m_wready, a_m_wlast, a_m_wdone, a_awid, a_awlock, a_awvalid, a_wlast, a_wvalid, a_bready;
    logic [1:0] a_m_wresp, a_awburst;
    logic [31:0] a_awaddr, a_wdata;
    logic [7:0] a_awlen;
    logic [2:0] a_awsize, a_awprot;
    logic [3:0] a_awcache, a_awqos, a_wstrb;

    logic b_m_wready, b_m_wlast, b_m_wdone, b_awid, b_awlock, b_awvalid, b_wlast, b_wvalid, b_bready;
    logic [1:0] b_m_wresp, b_awburst;
    logic [31:0] b_awaddr;
    logic [63:0] b_wdata;
    logic [7:0] b_awlen, b_wstrb;
    logic [2:0] b_awsize, b_awprot;
    logic [3:0] b_awcache, b_awqos;

    simple_axi_to_axi_write_burst #(.AXI_DATA_W(32), .MAX_BURST(256)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_wvalid_i(m_wvalid & ~sel), .m_wready_o(a_m_wready), .m_waddr_i(m_waddr),
        .m_wlen_i(m_wlen), .m_wdata_i(m_wdata[31:0]), .m_wlast_o(a_m_wlast),
        .m_wdone_o(a_m_wdone), .m_wresp_o(a_m_wresp),
        .axi_awid_o(a_awid), .axi_awaddr_o(a_awaddr), .axi_awlen_o(a_awlen), .axi_awsize_o(a_awsize),
        .axi_awburst_o(a_awburst), .axi_awlock_o(a_awlock), .axi_awcache_o(a_awcache),
        .axi_awprot_o(a_awprot), .axi_awqos_o(a_awqos), .axi_awvalid_o(a_awvalid),
        .axi_awready_i(awready & ~sel), .axi_wdata_o(a_wdata), .axi_wstrb_o(a_wstrb),
        .axi_wlast_o(a_wlast), .axi_wvalid_o(a_wvalid), .axi_wready_i(wready & ~sel),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid & ~sel), .axi_bready_o(a_bready)
    );

    simple_axi_to_axi_write_burst #(.AXI_DATA_W(64), .MAX_BURST(256)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_wvalid_i(m_wvalid & sel), .m_wready_o(b_m_wready), .m_waddr_i(m_waddr),
        .m_wlen_i(m_wlen), .m_wdata_i(m_wdata), .m_wlast_o(b_m_wlast),
        .m_wdone_o(b_m_wdone), .m_wresp_o(b_m_wresp),
        .axi_awid_o(b_awid), .axi_awaddr_o(b_awaddr), .axi_awlen_o(b_awlen), .axi_awsize_o(b_awsize),
        .axi_awburst_o(b_awburst), .axi_awlock_o(b_awlock), .axi_awcache_o(b_awcache),
        .axi_awprot_o(b_awprot), .axi_awqos_o(b_awqos), .axi_awvalid_o(b_awvalid),
        .axi_awready_i(awready & sel), .axi_wdata_o(b_wdata), .axi_wstrb_o(b_wstrb),
        .axi_wlast_o(b_wlast), .axi_wvalid_o(b_wvalid), .axi_wready_i(wready & sel),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid & sel), .axi_bready_o(b_bready)
    );

    // Selected-instance view of the outputs.
    logic aw_v, w_v, w_last, b_r, m_wr, m_wl, m_dn;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len, w_strb;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst, m_rsp;
    logic [63:0] w_data;
    always_comb begin
        aw_v     = sel ? b_awvalid : a_awvalid;
        aw_addr  = sel ? b_awaddr : a_awaddr;
        aw_len   = sel ? b_awlen : a_awlen;
        aw_size  = sel ? b_awsize : a_awsize;
        aw_burst = sel ? b_awburst : a_awburst;
        w_v      = sel ? b_wvalid : a_wvalid;
        w_data   = sel ? b_wdata : {32'h0, a_wdata};
        w_strb   = sel ? b_wstrb : {4'h0, a_wstrb};
        w_last   = sel ? b_wlast : a_wlast;
        b_r      = sel ? b_bready : a_bready;
        m_wr     = sel ? b_m_wready : a_m_wready;
        m_wl     = sel ? b_m_wlast : a_m_wlast;
        m_dn     = sel ? b_m_wdone : a_m_wdone;
        m_rsp    = sel ? b_m_wresp : a_m_wresp;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct packed { logic [63:0] data; logic [7:0] strb; logic last; logic mlast; } w_exp_t;

    aw_exp_t     aw_q[$];
    w_exp_t      w_q[$];
    logic [1:0]  resp_q[$];
    logic [31:0] aw_log_addr[$];
    logic [7:0]  aw_log_len[$];
    logic [7:0]  w_log_strb[$];
    logic [1:0]  bresp_plan[$];
    aw_exp_t     mon_ae;
    w_exp_t      mon_we;
    int done_cnt = 0;
    int w_budget = 0;
    int stall_pct = 0;
    int b_pend = 0;
    int b_idx = 0;
    int cyc_cnt = 0;
    int t_req = 0;
    int aw_first_cyc = -1;
    bit s_wlast_hs, s_b_hs;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [63:0] gen_data(input int req, input int idx);
        return {8'(req), 8'hC3, 16'(idx), 16'(idx * 7 + 1), 8'hA5, 8'(req + idx)};
    endfunction

    // Reference model: split into bursts and list every expected beat.
    task automatic push_expect(input bit s, input logic [31:0] addr, input int len,
                               input int req_id, input logic [1:0] resp);
        int bytes = s ? 8 : 4;
        int nbeats = (len + bytes - 1) / bytes;
        int r = len % bytes;
        int remaining = nbeats;
        int gidx = 0;
        int room, b;
        logic [31:0] a = addr;
        logic [63:0] d;
        aw_exp_t ae;
        w_exp_t we;
        while (remaining > 0) begin
            room = (4096 - int'(a[11:0])) / bytes;
            b = remaining;
            if (b > 256) b = 256;
            if (room < b) b = room;
            ae.addr = a;
            ae.len = 8'(b - 1);
            aw_q.push_back(ae);
            for (int j = 0; j < b; j++) begin
                d = gen_data(req_id, gidx);
                we.data = s ? d : {32'h0, d[31:0]};
                we.last = (j == b - 1);
                we.mlast = (gidx == nbeats - 1);
                we.strb = s ? 8'hFF : 8'h0F;
                if (we.mlast && r != 0) we.strb = 8'((1 << r) - 1);
                w_q.push_back(we);
                gidx++;
            end
            a = a + 32'(b * bytes);
            remaining -= b;
        end
        resp_q.push_back(resp);
    endtask

    // Drive one request and its data stream; abort_at >= 0 returns mid-stream.
    task automatic run_req(input bit s, input logic [31:0] addr, input int len, input int req_id,
                           input logic [1:0] resp, input int abort_at);
        int bytes = s ? 8 : 4;
        int nbeats = (len + bytes - 1) / bytes;
        int idx = 0;
        int cyc = 0;
        int done0 = done_cnt;
        bit acc;
        aw_log_addr.delete();
        aw_log_len.delete();
        w_log_strb.delete();
        b_idx = 0;
        push_expect(s, addr, len, req_id, resp);
        sel = s;
        m_waddr = addr;
        m_wlen = 20'(len);
        m_wdata = gen_data(req_id, 0);
        m_wvalid = 1'b1;
        t_req = cyc_cnt;
        aw_first_cyc = -1;
        while (idx < nbeats && cyc < 20000) begin
            @(negedge clk);
            acc = m_wr && m_wvalid;
            @(posedge clk); #1;
            if (acc) idx++;
            if (abort_at >= 0 && idx >= abort_at) return;
            m_wdata = gen_data(req_id, idx);
            m_wvalid = (idx < nbeats) && ($urandom_range(99) >= stall_pct);
            cyc++;
        end
        m_wvalid = 1'b0;
        chk("beat_stream_done", idx, nbeats);
        cyc = 0;
        while (done_cnt == done0 && cyc < 5000) begin
            @(posedge clk); #2;
            cyc++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("one_done", done_cnt - done0, 1);
        chk("aw_left", aw_q.size(), 0);
        chk("w_left", w_q.size(), 0);
        chk("resp_left", resp_q.size(), 0);
    endtask

    // Monitor: compare every handshake and completion against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_v && aw_first_cyc < 0) aw_first_cyc = cyc_cnt;
            if (aw_v && awready) begin
                chk("aw_expected", aw_q.size() != 0, 1);
                if (aw_q.size() != 0) begin
                    mon_ae = aw_q.pop_front();
                    chk("awaddr", aw_addr, mon_ae.addr);
                    chk("awlen", aw_len, mon_ae.len);
                    chk("awsize", aw_size, sel ? 3 : 2);
                    chk("awburst", aw_burst, 1);
                end
                aw_log_addr.push_back(aw_addr);
                aw_log_len.push_back(aw_len);
                w_budget += int'(aw_len) + 1;
            end
            if (w_v) chk("w_after_aw", w_budget > 0, 1);
            if (w_v && wready) begin
                chk("w_expected", w_q.size() != 0, 1);
                if (w_q.size() != 0) begin
                    mon_we = w_q.pop_front();
                    chk("wdata", w_data, mon_we.data);
                    chk("wstrb", w_strb, mon_we.strb);
                    chk("wlast", w_last, mon_we.last);
                    chk("m_wlast", m_wl, mon_we.mlast);
                end
                chk("m_wready", m_wr, 1);
                w_log_strb.push_back(w_strb);
                w_budget--;
            end
            if (m_dn) begin
                done_cnt++;
                chk("done_expected", resp_q.size() != 0, 1);
                if (resp_q.size() != 0) chk("m_wresp", m_rsp, resp_q.pop_front());
            end
        end
    end

    // AXI slave model with random ready/valid stalls.
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            s_wlast_hs = w_v && wready && w_last && rst_n;
            s_b_hs = bvalid && b_r;
            @(posedge clk); #1;
            if (s_wlast_hs) b_pend++;
            if (s_b_hs) begin
                bvalid = 1'b0;
            end else if (!bvalid && b_pend > 0 && $urandom_range(99) >= stall_pct) begin
                bvalid = 1'b1;
                bresp = (b_idx < bresp_plan.size()) ? bresp_plan[b_idx] : AXI_RESP_OKAY;
                b_idx++;
                b_pend--;
            end
            awready = $urandom_range(99) >= stall_pct;
            wready = $urandom_range(99) >= stall_pct;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; m_wvalid = 1'b0; m_waddr = '0; m_wlen = '0; m_wdata = '0; bid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", a_awvalid, 0);
        chk("rst_wvalid", a_wvalid, 0);
        chk("rst_wlast", a_wlast, 0);
        chk("rst_bready", a_bready, 0);
        chk("rst_m_wready", a_m_wready, 0);
        chk("rst_m_wlast", a_m_wlast, 0);
        chk("rst_m_wdone", a_m_wdone, 0);
        chk("rst_wstrb", a_wstrb, 0);
        chk("rst_awaddr", a_awaddr, 0);
        chk("rst_awlen", a_awlen, 0);
        chk("rst_m_wresp", a_m_wresp, 0);
        chk("tie_offs", {a_awlock, a_awcache, a_awprot, a_awqos, a_awid}, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 4 bytes at 0x100: single beat burst
        bresp_plan = '{AXI_RESP_OKAY};
        run_req(1'b0, 32'h100, 4, 1, AXI_RESP_OKAY, -1);
        chk("t1_aw_latency", aw_first_cyc - t_req, 2);
        chk("t1_bursts", aw_log_len.size(), 1);
        chk("t1_awaddr", aw_log_addr[0], 32'h100);
        chk("t1_awlen", aw_log_len[0], 0);
        chk("t1_strb", w_log_strb[0], 8'h0F);

        // 5 bytes: partial final beat
        bresp_plan = '{AXI_RESP_OKAY};
        run_req(1'b0, 32'h200, 5, 2, AXI_RESP_OKAY, -1);
        chk("t2_awlen", aw_log_len[0], 1);
        chk("t2_strb0", w_log_strb[0], 8'h0F);
        chk("t2_strb1", w_log_strb[1], 8'h01);

        // 64-bit instance, 13 bytes
        bresp_plan = '{AXI_RESP_OKAY};
        run_req(1'b1, 32'h40, 13, 3, AXI_RESP_OKAY, -1);
        chk("t3_awlen", aw_log_len[0], 1);
        chk("t3_strb0", w_log_strb[0], 8'hFF);
        chk("t3_strb1", w_log_strb[1], 8'h1F);

        // 4 KB boundary split
        bresp_plan = '{AXI_RESP_OKAY, AXI_RESP_OKAY};
        run_req(1'b0, 32'hFF8, 32, 4, AXI_RESP_OKAY, -1);
        chk("t4_bursts", aw_log_len.size(), 2);
        chk("t4_addr0", aw_log_addr[0], 32'hFF8);
        chk("t4_len0", aw_log_len[0], 1);
        chk("t4_addr1", aw_log_addr[1], 32'h1000);
        chk("t4_len1", aw_log_len[1], 5);

        // MAX_BURST split: 1300 beats
        bresp_plan = '{AXI_RESP_OKAY, AXI_RESP_OKAY, AXI_RESP_OKAY,
                       AXI_RESP_OKAY, AXI_RESP_OKAY, AXI_RESP_OKAY};
        run_req(1'b0, 32'h0, 5200, 5, AXI_RESP_OKAY, -1);
        chk("t5_bursts", aw_log_len.size(), 6);
        for (int i = 0; i < 6 && i < aw_log_len.size(); i++) begin
            chk("t5_addr", aw_log_addr[i], 32'(i * 32'h400));
            chk("t5_len", aw_log_len[i], (i < 5) ? 255 : 19);
        end

        // Random stalls, SLVERR on the middle burst
        stall_pct = 40;
        bresp_plan = '{AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_OKAY};
        run_req(1'b0, 32'h2000, 2087, 6, AXI_RESP_SLVERR, -1);
        chk("t6_bursts", aw_log_len.size(), 3);
        chk("t6_last_strb", w_log_strb[w_log_strb.size() - 1], 8'h07);
        stall_pct = 0;

        // Asynchronous reset in the middle of a W burst
        bresp_plan = '{AXI_RESP_OKAY};
        run_req(1'b0, 32'h300, 256, 7, AXI_RESP_OKAY, 10);
        chk("t7_in_w", a_wstrb, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_awvalid", a_awvalid, 0);
        chk("t7_wvalid", a_wvalid, 0);
        chk("t7_wlast", a_wlast, 0);
        chk("t7_bready", a_bready, 0);
        chk("t7_m_wready", a_m_wready, 0);
        chk("t7_m_wlast", a_m_wlast, 0);
        chk("t7_m_wdone", a_m_wdone, 0);
        chk("t7_wstrb", a_wstrb, 0);
        chk("t7_awaddr", a_awaddr, 0);
        chk("t7_awlen", a_awlen, 0);
        m_wvalid = 1'b0;
        aw_q.delete(); w_q.delete(); resp_q.delete();
        bvalid = 1'b0; b_pend = 0; b_idx = 0; w_budget = 0;
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t7_no_done", done_cnt, 0);
        bresp_plan = '{AXI_RESP_OKAY};
        run_req(1'b0, 32'h500, 8, 8, AXI_RESP_OKAY, -1);
        chk("t7_fresh_awlen", aw_log_len[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
